// File: rtl/mips_mem_pkg.sv
// Shared MEM-stage definitions: access-size encodings, byte-enable patterns and the
// store entry layout used by the store path (and later the load-extension unit).
package mips_mem_pkg;

  localparam int MEM_ADDR_W = 32;
  localparam int MEM_DATA_W = 32;
  localparam int MEM_BE_W   = MEM_DATA_W / 8;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } mem_size_e;

  localparam logic [MEM_BE_W-1:0] BE_ALL = 4'b1111;
  localparam logic [MEM_BE_W-1:0] BE_LO  = 4'b0011;
  localparam logic [MEM_BE_W-1:0] BE_HI  = 4'b1100;

  typedef struct packed {
    logic [MEM_ADDR_W-1:0] addr;
    logic [MEM_DATA_W-1:0] wdata;
    logic [MEM_BE_W-1:0]   be;
  } store_entry_t;

  // A store is illegal when its size is reserved or its address is not naturally aligned.
  function automatic logic store_illegal(input logic [1:0] size, input logic [1:0] addr_lo);
    logic ill;
    ill = 1'b0;
    case (size)
      SZ_BYTE: ill = 1'b0;
      SZ_HALF: ill = addr_lo[0];
      SZ_WORD: ill = (addr_lo != 2'b00);
      default: ill = 1'b1;
    endcase
    return ill;
  endfunction

endpackage

// File: rtl/store_align.sv
// Combinational store lane alignment: replicates the low bytes of rt onto the
// little-endian byte lanes and derives byte enables plus an illegal-access flag.
module store_align
  import mips_mem_pkg::*;
(
  input  logic [1:0]            size,
  input  logic [1:0]            addr_lo,
  input  logic [MEM_DATA_W-1:0] data,
  output logic [MEM_DATA_W-1:0] wdata,
  output logic [MEM_BE_W-1:0]   be,
  output logic                  illegal
);

  // Replication means every lane already holds the right byte; be selects which ones land.
  for (genvar gi = 0; gi < MEM_BE_W; gi++) begin : g_lane
    assign wdata[8*gi +: 8] = (size == SZ_BYTE) ? data[7:0] :
                              (size == SZ_HALF) ? data[8*(gi%2) +: 8] :
                                                  data[8*gi +: 8];
  end

  assign illegal = store_illegal(size, addr_lo);

  always_comb begin
    be = '0;
    if (!illegal) begin
      case (size)
        SZ_BYTE: be = 4'b0001 << addr_lo;
        SZ_HALF: be = addr_lo[1] ? BE_HI : BE_LO;
        SZ_WORD: be = BE_ALL;
        default: be = '0;
      endcase
    end
  end

endmodule

// File: rtl/store_write_buffer.sv
// MEM-stage store write buffer: aligns SB/SH/SW requests, drops misaligned ones with a
// one-cycle misalign pulse, and queues legal stores in a FIFO drained over valid/ready.
module store_write_buffer
  import mips_mem_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [ADDR_W-1:0]        req_addr,
  input  logic [DATA_W-1:0]        req_data,
  input  logic [1:0]               req_size,
  output logic                     mem_valid,
  input  logic                     mem_ready,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  output logic [3:0]               mem_be,
  output logic                     misalign,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  store_entry_t           fifo_mem [DEPTH];
  store_entry_t           entry_in;
  store_entry_t           head_entry;
  logic [PTR_W-1:0]       wr_ptr_reg;
  logic [PTR_W-1:0]       rd_ptr_reg;
  logic [CNT_W-1:0]       count_reg;
  logic [CNT_W-1:0]       count_next;
  logic                   req_ready_reg;
  logic                   misalign_reg;

  logic [DATA_W-1:0]      align_wdata;
  logic [3:0]             align_be;
  logic                   align_illegal;
  logic                   accept;
  logic                   push;
  logic                   pop;
  logic                   not_empty;

  store_align u_align (
    .size    (req_size),
    .addr_lo (req_addr[1:0]),
    .data    (req_data),
    .wdata   (align_wdata),
    .be      (align_be),
    .illegal (align_illegal)
  );

  assign not_empty = (count_reg != '0);
  assign accept    = req_valid && req_ready_reg;
  assign push      = accept && !align_illegal;
  assign pop       = not_empty && mem_ready;

  always_comb begin
    entry_in       = '0;
    entry_in.addr  = {req_addr[ADDR_W-1:2], 2'b00};
    entry_in.wdata = align_wdata;
    entry_in.be    = align_be;
  end

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + CNT_W'(1);
      2'b01:   count_next = count_reg - CNT_W'(1);
      default: count_next = count_reg;
    endcase
  end

  // req_ready is registered from next occupancy, so a pop on a full buffer only
  // reopens the request side on the following cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      req_ready_reg <= 1'b1;
      misalign_reg  <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      count_reg     <= count_next;
      req_ready_reg <= (count_next != CNT_W'(DEPTH));
      misalign_reg  <= accept && align_illegal;
    end
  end

  // Storage carries no reset: occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_reg] <= entry_in;
  end

  assign head_entry = fifo_mem[rd_ptr_reg];

  assign mem_valid = not_empty;
  assign mem_addr  = not_empty ? head_entry.addr  : '0;
  assign mem_wdata = not_empty ? head_entry.wdata : '0;
  assign mem_be    = not_empty ? head_entry.be    : '0;
  assign req_ready = req_ready_reg;
  assign misalign  = misalign_reg;
  assign count     = count_reg;

endmodule

// File: tb/tb_store_write_buffer.sv
// Scoreboard bench for store_write_buffer: expected stores queued at handshake,
// checked against each memory write as the FIFO drains.
module tb_store_write_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic [1:0]  req_size;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        misalign;
  logic [2:0]  count;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  exp_t prev_out;
  bit   stall_prev = 0;
  bit   rand_on    = 0;
  int   n_checks   = 0;
  int   n_pass     = 0;

  always #5 clk = ~clk;

  store_write_buffer #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_size  (req_size),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .misalign  (misalign),
    .count     (count)
  );

  function automatic logic model(input logic [31:0] addr, input logic [31:0] d,
                                 input logic [1:0] sz, output exp_t e);
    logic [1:0] a;
    logic       ill;
    a       = addr[1:0];
    e.addr  = {addr[31:2], 2'b00};
    e.wdata = 32'h0;
    e.be    = 4'h0;
    ill     = 1'b0;
    case (sz)
      2'b00: begin e.wdata = {4{d[7:0]}};  e.be = 4'b0001 << a; end
      2'b01: begin e.wdata = {2{d[15:0]}}; e.be = a[1] ? 4'b1100 : 4'b0011; ill = a[0]; end
      2'b10: begin e.wdata = d;            e.be = 4'b1111; ill = (a != 2'b00); end
      default: ill = 1'b1;
    endcase
    return ill;
  endfunction

  // Memory-side monitor: every write must match the scoreboard head; stalled outputs must hold.
  always @(negedge clk) begin
    if (!rst) begin
      if (stall_prev) begin
        n_checks++;
        if (mem_valid !== 1'b1 || mem_addr !== prev_out.addr ||
            mem_wdata !== prev_out.wdata || mem_be !== prev_out.be)
          $display("FAIL stall_hold: got v=%b %h/%h/%b required v=1 %h/%h/%b",
                   mem_valid, mem_addr, mem_wdata, mem_be, prev_out.addr, prev_out.wdata, prev_out.be);
        else n_pass++;
      end
      if (mem_valid && mem_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL unexpected_write: got %h/%h/%b required no write", mem_addr, mem_wdata, mem_be);
        end else begin
          mon_e = exp_q.pop_front();
          if (mem_addr !== mon_e.addr || mem_wdata !== mon_e.wdata || mem_be !== mon_e.be)
            $display("FAIL write_data: got %h/%h/%b required %h/%h/%b",
                     mem_addr, mem_wdata, mem_be, mon_e.addr, mon_e.wdata, mon_e.be);
          else begin
            n_pass++;
            $display("write addr=%h wdata=%h be=%b", mem_addr, mem_wdata, mem_be);
          end
        end
      end
      stall_prev     = mem_valid && !mem_ready;
      prev_out.addr  = mem_addr;
      prev_out.wdata = mem_wdata;
      prev_out.be    = mem_be;
    end else begin
      stall_prev = 0;
    end
  end

  task automatic send(input logic [31:0] addr, input logic [31:0] d, input logic [1:0] sz);
    exp_t e;
    logic ill;
    int   waited;
    ill = model(addr, d, sz, e);
    @(posedge clk); #1;
    req_valid = 1'b1; req_addr = addr; req_data = d; req_size = sz;
    waited = 0;
    @(negedge clk);
    while (!req_ready) begin
      waited++;
      if (waited > 200) begin
        n_checks++;
        $display("FAIL send_timeout: got req_ready=0 required 1 within 200 cycles");
        req_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    if (!ill) exp_q.push_back(e);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (misalign !== ill) $display("FAIL misalign_pulse: got %b required %b", misalign, ill);
    else n_pass++;
  endtask

  task automatic drain();
    int waited;
    @(posedge clk); #1;
    mem_ready = 1'b1;
    waited = 0;
    @(negedge clk);
    while (count !== 3'd0 && waited < 500) begin
      waited++;
      @(negedge clk);
    end
    n_checks++;
    if (count !== 3'd0 || exp_q.size() != 0)
      $display("FAIL drain: got count=%0d pending=%0d required 0/0", count, exp_q.size());
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_data = '0; req_size = '0; mem_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b1 || mem_valid !== 1'b0 || misalign !== 1'b0 || count !== 3'd0 ||
        mem_addr !== 32'h0 || mem_wdata !== 32'h0 || mem_be !== 4'h0)
      $display("FAIL reset_state: got rdy=%b v=%b mis=%b cnt=%0d %h/%h/%b required 1 0 0 0 zeros",
               req_ready, mem_valid, misalign, count, mem_addr, mem_wdata, mem_be);
    else n_pass++;
  endtask

  task automatic test_byte();
    mem_ready = 1'b0;
    send(32'h0000_1003, 32'h0000_00A5, 2'b00);
    n_checks++;
    if (mem_valid !== 1'b1 || mem_addr !== 32'h1000 || mem_wdata !== 32'hA5A5A5A5 || mem_be !== 4'b1000)
      $display("FAIL sb_latency: got v=%b %h/%h/%b required 1 00001000/a5a5a5a5/1000",
               mem_valid, mem_addr, mem_wdata, mem_be);
    else n_pass++;
    drain();
  endtask

  task automatic test_half();
    mem_ready = 1'b0;
    send(32'h0000_2002, 32'h0000_BEEF, 2'b01);
    n_checks++;
    if (mem_addr !== 32'h2000 || mem_wdata !== 32'hBEEFBEEF || mem_be !== 4'b1100)
      $display("FAIL sh_align: got %h/%h/%b required 00002000/beefbeef/1100", mem_addr, mem_wdata, mem_be);
    else n_pass++;
    drain();
    send(32'h0000_2001, 32'h0000_BEEF, 2'b01);
    send(32'h0000_3002, 32'h1234_5678, 2'b10);
    send(32'h0000_3000, 32'h1234_5678, 2'b11);
    @(negedge clk);
    n_checks++;
    if (misalign !== 1'b0 || count !== 3'd0 || mem_valid !== 1'b0)
      $display("FAIL illegal_dropped: got mis=%b cnt=%0d v=%b required 0 0 0", misalign, count, mem_valid);
    else n_pass++;
  endtask

  task automatic fill_four();
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(32'(i * 4), 32'hC0DE_0000 + 32'(i), 2'b10);
    n_checks++;
    if (count !== 3'd4 || req_ready !== 1'b0)
      $display("FAIL full_state: got cnt=%0d rdy=%b required 4 0", count, req_ready);
    else n_pass++;
  endtask

  task automatic test_full_hold();
    int waited;
    exp_t e;
    logic ill;
    fill_four();
    ill = model(32'h10, 32'h5555_AAAA, 2'b10, e);
    @(posedge clk); #1;
    req_valid = 1'b1; req_addr = 32'h10; req_data = 32'h5555_AAAA; req_size = 2'b10;
    repeat (3) begin
      @(negedge clk);
      n_checks++;
      if (req_ready !== 1'b0 || count !== 3'd4)
        $display("FAIL fifth_held: got rdy=%b cnt=%0d required 0 4", req_ready, count);
      else n_pass++;
    end
    @(posedge clk); #1;
    mem_ready = 1'b1;
    waited = 0;
    @(negedge clk);
    while (!req_ready && waited < 20) begin waited++; @(negedge clk); end
    n_checks++;
    if (!req_ready) $display("FAIL fifth_accept: got rdy=0 required 1");
    else begin
      n_pass++;
      if (!ill) exp_q.push_back(e);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    drain();
  endtask

  task automatic test_full_pop_push();
    exp_t e;
    logic ill;
    fill_four();
    ill = model(32'h40, 32'hFACE_0040, 2'b10, e);
    @(posedge clk); #1;
    mem_ready = 1'b1; req_valid = 1'b1; req_addr = 32'h40; req_data = 32'hFACE_0040; req_size = 2'b10;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b0) $display("FAIL full_refuse: got rdy=%b required 0", req_ready);
    else n_pass++;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if (count !== 3'd3 || req_ready !== 1'b1)
      $display("FAIL pop_only: got cnt=%0d rdy=%b required 3 1", count, req_ready);
    else n_pass++;
    if (!ill) exp_q.push_back(e);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (count !== 3'd4) $display("FAIL push_next: got cnt=%0d required 4", count);
    else n_pass++;
    drain();
  endtask

  task automatic test_random();
    rand_on = 1;
    fork
      begin
        for (int i = 0; i < 1000; i++)
          send($urandom, $urandom, 2'($urandom_range(0, 3)));
        rand_on = 0;
      end
      begin
        while (rand_on) begin
          @(posedge clk); #1;
          mem_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    drain();
  endtask

  task automatic test_reset_mid();
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(32'h100 + 32'(i * 4), 32'hDEAD_0000 + 32'(i), 2'b10);
    @(posedge clk); #1;
    rst = 1'b1; mem_ready = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (count !== 3'd0 || mem_valid !== 1'b0 || req_ready !== 1'b1)
      $display("FAIL reset_flush: got cnt=%0d v=%b rdy=%b required 0 0 1", count, mem_valid, req_ready);
    else n_pass++;
    repeat (5) begin
      @(negedge clk);
      n_checks++;
      if (mem_valid !== 1'b0) $display("FAIL post_reset_idle: got v=%b required 0", mem_valid);
      else n_pass++;
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: got no finish required finish within 5 ms");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_byte();
    test_half();
    test_full_hold();
    test_full_pop_push();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
